// File: rtl/seg_effect_pkg.sv
// Shared effect-mode codes, blank pattern and per-mode step range for the
// segment reveal/scan driver.
package seg_effect_pkg;

  localparam logic [1:0] MODE_REVEAL_L2R = 2'd0;
  localparam logic [1:0] MODE_REVEAL_R2L = 2'd1;
  localparam logic [1:0] MODE_PINGPONG   = 2'd2;
  localparam logic [1:0] MODE_BLINK      = 2'd3;

  // Wide enough for any supported segment width; users slice down to SEG_W.
  localparam int unsigned        SEG_W_MAX = 32;
  localparam logic [SEG_W_MAX-1:0] LED_BLANK = {SEG_W_MAX{1'b1}};

  // Highest step index reached before the sequence wraps to step 0.
  function automatic int unsigned step_max(input logic [1:0] mode, input int unsigned n);
    case (mode)
      MODE_REVEAL_L2R, MODE_REVEAL_R2L: return n;
      MODE_PINGPONG:                    return 2 * n - 1;
      default:                          return 1;
    endcase
  endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running counter with a run-time terminal; tick is high in the cycle
// the count has reached (or passed) term, and the count clears behind it.
module tick_div #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         tick
);

  logic [W-1:0] r_cnt;

  // >= so that a terminal lowered mid-count fires at once instead of wrapping.
  assign tick = !clr && (r_cnt >= term);

  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/seg_reveal_scan.sv
// Multiplexed 7-segment scan driver: steps through a reveal/hide effect and
// blanks each scanned digit that the current step does not show.
module seg_reveal_scan
  import seg_effect_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 7,
  parameter int unsigned SEG_W      = 7,
  parameter int unsigned SCAN_DIV   = 25000,
  parameter int unsigned BASE_DIV   = 50000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [1:0]                  frequency,
  input  logic [1:0]                  mode,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  output logic [NUM_DIGITS-1:0]       trans,
  output logic [SEG_W-1:0]            led7seg,
  output logic                        cycle_done
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned STEP_W = $clog2(2 * NUM_DIGITS);
  localparam int unsigned SCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BCNT_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [SEG_W-1:0] BLANK = SEG_W'(LED_BLANK);

  logic [STEP_W-1:0]     r_step, w_step_nxt, w_step_max;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [1:0]            r_mode;
  logic [NUM_DIGITS-1:0] r_trans;
  logic [SEG_W-1:0]      r_led, w_seg;
  logic                  r_done, w_wrap, w_vis;
  logic                  w_mode_chg, w_step_clr, w_scan_tick, w_step_tick;
  logic [BCNT_W-1:0]     w_step_term;

  assign w_mode_chg  = en && (mode != r_mode);
  assign w_step_clr  = !en || w_mode_chg;
  assign w_step_max  = STEP_W'(step_max(r_mode, NUM_DIGITS));
  assign w_step_term = BCNT_W'((BASE_DIV >> frequency) - 1);

  tick_div #(.W(SCNT_W)) u_scan_div (
    .clk (clk),
    .rst (rst),
    .clr (!en),
    .term(SCNT_W'(SCAN_DIV - 1)),
    .tick(w_scan_tick)
  );

  tick_div #(.W(BCNT_W)) u_step_div (
    .clk (clk),
    .rst (rst),
    .clr (w_step_clr),
    .term(w_step_term),
    .tick(w_step_tick)
  );

  // Whether digit i is lit at step s of effect m.
  function automatic logic vis(input logic [1:0] m, input logic [STEP_W-1:0] s,
                               input logic [IDX_W-1:0] i);
    int unsigned si;
    int unsigned ii;
    int unsigned lvl;
    si  = 32'(s);
    ii  = 32'(i);
    lvl = (si <= NUM_DIGITS) ? si : 2 * NUM_DIGITS - si;
    case (m)
      MODE_REVEAL_L2R: return ii < si;
      MODE_REVEAL_R2L: return ii + si >= NUM_DIGITS;
      MODE_PINGPONG:   return ii < lvl;
      default:         return si == 1;
    endcase
  endfunction

  assign w_vis = vis(r_mode, r_step, r_idx);
  assign w_seg = seg_in[32'(r_idx) * SEG_W +: SEG_W];

  // Step / scan-index next state.
  always_comb begin
    w_step_nxt = r_step;
    w_idx_nxt  = r_idx;
    w_wrap     = 1'b0;
    if (!en) begin
      w_step_nxt = '0;
      w_idx_nxt  = '0;
    end else begin
      if (w_scan_tick) begin
        w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end
      if (w_mode_chg) begin
        w_step_nxt = '0;
      end else if (w_step_tick) begin
        if (r_step >= w_step_max) begin
          w_step_nxt = '0;
          w_wrap     = 1'b1;
        end else begin
          w_step_nxt = r_step + STEP_W'(1);
        end
      end
    end
  end

  // r_mode follows mode every cycle so a change is seen exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step  <= '0;
      r_idx   <= '0;
      r_mode  <= mode;
      r_trans <= '1;
      r_led   <= BLANK;
      r_done  <= 1'b0;
    end else begin
      r_step <= w_step_nxt;
      r_idx  <= w_idx_nxt;
      r_mode <= mode;
      r_done <= w_wrap;
      if (en) begin
        r_trans <= ~(NUM_DIGITS'(1) << r_idx);
        r_led   <= w_vis ? w_seg : BLANK;
      end else begin
        r_trans <= '1;
        r_led   <= BLANK;
      end
    end
  end

  assign trans      = r_trans;
  assign led7seg    = r_led;
  assign cycle_done = r_done;

endmodule
